// File: rtl/daq_hnode_rd_sched_if.sv
// Trigger, configuration, node-array and output-stream signals of the header-node read scheduler.
// slave is the scheduler's view; master is the view of the logic driving it.
interface daq_hnode_rd_sched_if #(
    parameter int CELLS  = 4,
    parameter int DATA_W = 32,
    parameter int BCID_W = 12,
    parameter int WIN_W  = 8
);
    logic                    trig_valid_i;
    logic [BCID_W-1:0]       trig_bcid_i;
    logic                    trig_ready_o;
    logic [WIN_W-1:0]        cfg_win_width_i;
    logic [CELLS-1:0]        cfg_mask_i;
    logic                    err_clr_i;
    logic [CELLS-1:0]        node_en_o;
    logic [CELLS-1:0]        node_ready_i;
    logic [CELLS*DATA_W-1:0] node_data_i;
    logic [CELLS-1:0]        node_rd_strb_o;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [DATA_W-1:0]       out_data_o;
    logic [3:0]              out_sel_o;
    logic [BCID_W-1:0]       out_bcid_o;
    logic                    out_last_o;
    logic                    busy_o;
    logic [CELLS-1:0]        timeout_err_o;

    modport slave (
        input  trig_valid_i, trig_bcid_i, cfg_win_width_i, cfg_mask_i, err_clr_i,
               node_ready_i, node_data_i, out_ready_i,
        output trig_ready_o, node_en_o, node_rd_strb_o, out_valid_o, out_data_o,
               out_sel_o, out_bcid_o, out_last_o, busy_o, timeout_err_o
    );

    modport master (
        output trig_valid_i, trig_bcid_i, cfg_win_width_i, cfg_mask_i, err_clr_i,
               node_ready_i, node_data_i, out_ready_i,
        input  trig_ready_o, node_en_o, node_rd_strb_o, out_valid_o, out_data_o,
               out_sel_o, out_bcid_o, out_last_o, busy_o, timeout_err_o
    );
endinterface

// File: rtl/daq_hnode_rd_sched.sv
// Event scheduler for a row of header nodes: opens the window on unmasked nodes, then drains one word per cell in order.
// Latency: node_en_o rises the cycle after trigger accept; output word is combinational from node_ready_i while draining.
// Backpressure: out_ready_i low holds the current cell (valid/data stable, no strobe, timeout paused).
module daq_hnode_rd_sched #(
    parameter int CELLS   = 4,
    parameter int DATA_W  = 32,
    parameter int BCID_W  = 12,
    parameter int WIN_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                clk320,
    input  logic                rst_n,
    daq_hnode_rd_sched_if.slave bus
);
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_OPEN, S_DRAIN} state_t;

    state_t            r_state, w_state_nxt;
    logic [CELLS-1:0]  r_mask, w_mask_nxt;
    logic [CELLS-1:0]  r_en, w_en_nxt;
    logic [CELLS-1:0]  r_err, w_err_set;
    logic [BCID_W-1:0] r_bcid, w_bcid_nxt;
    logic [WIN_W-1:0]  r_win_cnt, w_win_cnt_nxt;
    logic [TO_W-1:0]   r_to_cnt, w_to_cnt_nxt;
    logic [3:0]        r_ptr, w_ptr_nxt;
    logic [3:0]        w_first, w_next;
    logic              w_has_next;
    logic [CELLS-1:0]  w_cur_oh;
    logic              w_rdy;
    logic [DATA_W-1:0] w_dat;
    logic              w_in_drain, w_vld, w_hs, w_to_hit, w_trig_rdy;

    // Cell scans over the frozen mask: lowest unmasked cell and next unmasked cell above ptr.
    always_comb begin
        w_first    = '0;
        w_next     = '0;
        w_has_next = 1'b0;
        w_rdy      = 1'b0;
        w_dat      = '0;
        w_cur_oh   = '0;
        for (int k = CELLS - 1; k >= 0; k--) begin
            if (!r_mask[k]) begin
                w_first = 4'(k);
                if (4'(k) > r_ptr) begin
                    w_next     = 4'(k);
                    w_has_next = 1'b1;
                end
            end
        end
        for (int k = 0; k < CELLS; k++) begin
            if (r_ptr == 4'(k)) begin
                w_rdy       = bus.node_ready_i[k];
                w_dat       = bus.node_data_i[k*DATA_W +: DATA_W];
                w_cur_oh[k] = 1'b1;
            end
        end
    end

    assign w_in_drain = (r_state == S_DRAIN);
    assign w_vld      = w_in_drain & w_rdy;
    assign w_hs       = w_vld & bus.out_ready_i;
    assign w_to_hit   = w_in_drain & ~w_rdy & (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_mask_nxt    = r_mask;
        w_en_nxt      = r_en;
        w_bcid_nxt    = r_bcid;
        w_win_cnt_nxt = r_win_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        w_ptr_nxt     = r_ptr;
        w_err_set     = '0;
        w_trig_rdy    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_trig_rdy = 1'b1;
                if (bus.trig_valid_i) begin
                    w_bcid_nxt = bus.trig_bcid_i;
                    w_mask_nxt = bus.cfg_mask_i;
                    if (!(&bus.cfg_mask_i)) begin
                        w_state_nxt   = S_OPEN;
                        w_win_cnt_nxt = '0;
                        w_en_nxt      = ~bus.cfg_mask_i;
                    end
                end
            end
            S_OPEN: begin
                if (r_win_cnt >= bus.cfg_win_width_i) begin
                    w_state_nxt  = S_DRAIN;
                    w_en_nxt     = '0;
                    w_ptr_nxt    = w_first;
                    w_to_cnt_nxt = '0;
                end else begin
                    w_win_cnt_nxt = r_win_cnt + WIN_W'(1);
                end
            end
            S_DRAIN: begin
                if (w_hs || w_to_hit) begin
                    w_to_cnt_nxt = '0;
                    if (w_to_hit) w_err_set = w_cur_oh;
                    if (w_has_next) w_ptr_nxt = w_next;
                    else            w_state_nxt = S_IDLE;
                end else if (!w_rdy) begin
                    // Stalled-by-downstream cycles have w_rdy=1 and so never reach here.
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk320 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mask    <= '0;
            r_en      <= '0;
            r_err     <= '0;
            r_bcid    <= '0;
            r_win_cnt <= '0;
            r_to_cnt  <= '0;
            r_ptr     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mask    <= w_mask_nxt;
            r_en      <= w_en_nxt;
            r_err     <= (r_err & ~{CELLS{bus.err_clr_i}}) | w_err_set;
            r_bcid    <= w_bcid_nxt;
            r_win_cnt <= w_win_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_ptr     <= w_ptr_nxt;
        end
    end

    assign bus.trig_ready_o   = w_trig_rdy;
    assign bus.busy_o         = (r_state != S_IDLE);
    assign bus.node_en_o      = r_en;
    assign bus.node_rd_strb_o = w_hs ? w_cur_oh : '0;
    assign bus.out_valid_o    = w_vld;
    assign bus.out_data_o     = w_in_drain ? w_dat : '0;
    assign bus.out_sel_o      = w_in_drain ? r_ptr : 4'd0;
    assign bus.out_bcid_o     = r_bcid;
    assign bus.out_last_o     = w_in_drain & ~w_has_next;
    assign bus.timeout_err_o  = r_err;
endmodule
